led_bank: RTL

Parametrised multi-channel LED driver: N_LEDS independent outputs, each selectable OFF / ON / BLINK / PWM through a single valid/ready configuration port. A shared prescaler sets the blink time base, so blink periods are set in ticks rather than raw clock cycles. A shared free-running counter sets the PWM frame. Sits between the board-level control logic (or a register bank) and the LED pins, replacing single-LED hard-coded blinkers.

---
 rtl/led_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/led_bank.sv
// led_bank: N-channel LED driver with OFF/ON/BLINK/PWM modes behind one valid/ready config port.
// Optional LED_BLINK_PWM_EN: PWM-dims the on-phase of BLINK channels using the channel duty.
module led_bank #(
  parameter int unsigned N_LEDS   = 4,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned PERIOD_W = 16,
  localparam int unsigned CHAN_W  = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [DUTY_W-1:0]   cfg_duty,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic [N_LEDS-1:0]   led
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e               mode;
    logic [DUTY_W-1:0]   duty;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic                phase;
  } chan_t;

  logic                cfg_ready_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [DUTY_W-1:0]   pwm_q, pwm_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  chan_t               chan_q [N_LEDS];
  chan_t               chan_d [N_LEDS];
  logic                tick_c;
  logic                accept_c;

  // Last counter value of a half-period; period 0 behaves as period 1.
  function automatic logic [PERIOD_W-1:0] last_cnt(input logic [PERIOD_W-1:0] period);
    return (period == '0) ? '0 : period - PERIOD_W'(1);
  endfunction

  assign cfg_ready = cfg_ready_q;
  assign led       = led_q;

  always_comb begin
    tick_c   = (pre_q == PRE_W'(PRESCALE - 1));
    pre_d    = tick_c ? '0 : pre_q + PRE_W'(1);
    pwm_d    = pwm_q + DUTY_W'(1);
    accept_c = cfg_valid & cfg_ready_q & (32'(cfg_chan) < N_LEDS);
    led_d    = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      chan_d[i] = chan_q[i];
      if (chan_q[i].mode == MODE_BLINK && tick_c) begin
        if (chan_q[i].cnt >= last_cnt(chan_q[i].period)) begin
          chan_d[i].cnt   = '0;
          chan_d[i].phase = ~chan_q[i].phase;
        end else begin
          chan_d[i].cnt   = chan_q[i].cnt + PERIOD_W'(1);
        end
      end
      // A write to this channel overrides any tick in the same cycle.
      if (accept_c && (32'(cfg_chan) == i)) begin
        chan_d[i].mode   = mode_e'(cfg_mode);
        chan_d[i].duty   = cfg_duty;
        chan_d[i].period = cfg_period;
        chan_d[i].cnt    = '0;
        chan_d[i].phase  = 1'b0;
      end
      unique case (chan_q[i].mode)
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_PWM:   led_d[i] = (pwm_q < chan_q[i].duty);
`ifdef LED_BLINK_PWM_EN
        MODE_BLINK: led_d[i] = chan_q[i].phase & (pwm_q < chan_q[i].duty);
`else
        MODE_BLINK: led_d[i] = chan_q[i].phase;
`endif
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready_q <= 1'b0;
      pre_q       <= '0;
      pwm_q       <= '0;
      led_q       <= '0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        chan_q[i] <= '0;
      end
    end else begin
      cfg_ready_q <= 1'b1;
      pre_q       <= pre_d;
      pwm_q       <= pwm_d;
      led_q       <= led_d;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
        chan_q[i] <= chan_d[i];
      end
    end
  end

endmodule
